// File: rtl/syn_cortex_lb_arb_pkg.sv
// syn_cortex_lb_arb_pkg: shared types for the two-master cortex LB arbiter.
// FSM encoding, per-master request bundle and timeout read pattern.
package syn_cortex_lb_arb_pkg;

   // Request bundle field widths; P_ADDR_W / P_DATA_W must not exceed them.
   localparam int LB_ADDR_W = 16;
   localparam int LB_DATA_W = 32;

   localparam logic [31:0] LB_ARB_TOUT_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } lb_arb_fsm_t;

   typedef struct packed {
      logic                 pend;
      logic                 is_wr;
      logic [LB_ADDR_W-1:0] addr;
      logic [LB_DATA_W-1:0] data;
   } lb_req_t;

endpackage

// File: rtl/syn_lb_req_hold.sv
// syn_lb_req_hold: one-deep request holding register for one LB master.
// Ports: clk/rst_n, rd_en/wr_en/addr/wr_data in, owned/clr from arbiter,
// req (held bundle) and ovf (request dropped this cycle) out.
import syn_cortex_lb_arb_pkg::*;

module syn_lb_req_hold #(
   parameter int P_DATA_W = 32,
   parameter int P_ADDR_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                rd_en,
   input  logic                wr_en,
   input  logic [P_ADDR_W-1:0] addr,
   input  logic [P_DATA_W-1:0] wr_data,
   input  logic                owned,
   input  logic                clr,
   output lb_req_t             req,
   output logic                ovf
);

   logic hit;

   assign hit = rd_en | wr_en;
   assign ovf = hit & (req.pend | owned);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req <= '0;
      end else begin
         if (clr) begin
            req.pend <= 1'b0;
         end
         if (hit && !ovf) begin
            req.pend  <= 1'b1;
            // rd_en+wr_en together collapses to a write
            req.is_wr <= wr_en;
            req.addr  <= LB_ADDR_W'(addr);
            req.data  <= LB_DATA_W'(wr_data);
         end
      end
   end

endmodule

// File: rtl/syn_cortex_lb_arb.sv
// syn_cortex_lb_arb: round-robin arbiter sharing the cortex LB slave port
// between master0 (m0_*) and master1 (m1_*), one transaction at a time.
// Ports: clk_ir, rst_il (async low); per-master rd/wr pulses, addr,
// wr_data in and rd/wr valid, rd_data out; slave s_* request/response;
// busy_oh, ovf_oh (sticky drop), tout_oh (sticky timeout).
// Macro SYN_CORTEX_LB_ARB_TIMEOUT_EN enables the WAIT timeout counter.
import syn_cortex_lb_arb_pkg::*;

module syn_cortex_lb_arb #(
   parameter int P_DATA_W  = 32,
   parameter int P_ADDR_W  = 16,
   parameter int P_TIMEOUT = 255
) (
   input  logic                clk_ir,
   input  logic                rst_il,
   input  logic                m0_rd_en_ih,
   input  logic                m0_wr_en_ih,
   input  logic [P_ADDR_W-1:0] m0_addr_id,
   input  logic [P_DATA_W-1:0] m0_wr_data_id,
   output logic                m0_rd_valid_oh,
   output logic                m0_wr_valid_oh,
   output logic [P_DATA_W-1:0] m0_rd_data_od,
   input  logic                m1_rd_en_ih,
   input  logic                m1_wr_en_ih,
   input  logic [P_ADDR_W-1:0] m1_addr_id,
   input  logic [P_DATA_W-1:0] m1_wr_data_id,
   output logic                m1_rd_valid_oh,
   output logic                m1_wr_valid_oh,
   output logic [P_DATA_W-1:0] m1_rd_data_od,
   output logic                s_rd_en_oh,
   output logic                s_wr_en_oh,
   output logic [P_ADDR_W-1:0] s_addr_od,
   output logic [P_DATA_W-1:0] s_wr_data_od,
   input  logic                s_rd_valid_ih,
   input  logic                s_wr_valid_ih,
   input  logic [P_DATA_W-1:0] s_rd_data_id,
   output logic                busy_oh,
   output logic                ovf_oh,
   output logic                tout_oh
);

   lb_arb_fsm_t         state;
   lb_req_t             req0;
   lb_req_t             req1;
   lb_req_t             sel;
   logic                ovf0;
   logic                ovf1;
   logic                gnt;
   logic                last;
   logic                cur_wr;
   logic                any;
   logic                pick;
   logic                sv;
   logic                done;
   logic                live;
   logic [P_DATA_W-1:0] rsp;

   // Owner is locked out during ISSUE/WAIT; RESP accepts its next request.
   assign live = (state == ISSUE) || (state == WAIT);

   syn_lb_req_hold #(
      .P_DATA_W (P_DATA_W),
      .P_ADDR_W (P_ADDR_W)
   ) u_hold0 (
      .clk     (clk_ir),
      .rst_n   (rst_il),
      .rd_en   (m0_rd_en_ih),
      .wr_en   (m0_wr_en_ih),
      .addr    (m0_addr_id),
      .wr_data (m0_wr_data_id),
      .owned   (live && !gnt),
      .clr     (state == ISSUE && !gnt),
      .req     (req0),
      .ovf     (ovf0)
   );

   syn_lb_req_hold #(
      .P_DATA_W (P_DATA_W),
      .P_ADDR_W (P_ADDR_W)
   ) u_hold1 (
      .clk     (clk_ir),
      .rst_n   (rst_il),
      .rd_en   (m1_rd_en_ih),
      .wr_en   (m1_wr_en_ih),
      .addr    (m1_addr_id),
      .wr_data (m1_wr_data_id),
      .owned   (live && gnt),
      .clr     (state == ISSUE && gnt),
      .req     (req1),
      .ovf     (ovf1)
   );

   assign busy_oh = (state != IDLE);
   assign any     = req0.pend | req1.pend;
   // On a tie the master that did not win last time goes next.
   assign pick    = (req0.pend & req1.pend) ? ~last : req1.pend;
   assign sel     = pick ? req1 : req0;
   assign sv      = s_rd_valid_ih | s_wr_valid_ih;

`ifdef SYN_CORTEX_LB_ARB_TIMEOUT_EN
   logic [15:0] cnt;
   logic        to_hit;

   // A slave valid in the expiry cycle wins over the timeout.
   assign to_hit = (state == WAIT) && !sv && (cnt == 16'(P_TIMEOUT));

   always_ff @(posedge clk_ir or negedge rst_il) begin
      if (!rst_il) begin
         cnt     <= '0;
         tout_oh <= 1'b0;
      end else begin
         if (state == ISSUE) begin
            cnt <= '0;
         end else if (state == WAIT && !done) begin
            cnt <= cnt + 16'd1;
         end
         if (to_hit) begin
            tout_oh <= 1'b1;
         end
      end
   end
`else
   assign tout_oh = 1'b0;
`endif

   always_comb begin
      done = live && sv;
      rsp  = s_rd_data_id;
`ifdef SYN_CORTEX_LB_ARB_TIMEOUT_EN
      if (to_hit) begin
         done = 1'b1;
         rsp  = P_DATA_W'(LB_ARB_TOUT_DATA);
      end
`endif
   end

   always_ff @(posedge clk_ir or negedge rst_il) begin
      if (!rst_il) begin
         state          <= IDLE;
         gnt            <= 1'b0;
         last           <= 1'b1;
         cur_wr         <= 1'b0;
         s_rd_en_oh     <= 1'b0;
         s_wr_en_oh     <= 1'b0;
         s_addr_od      <= '0;
         s_wr_data_od   <= '0;
         m0_rd_valid_oh <= 1'b0;
         m0_wr_valid_oh <= 1'b0;
         m0_rd_data_od  <= '0;
         m1_rd_valid_oh <= 1'b0;
         m1_wr_valid_oh <= 1'b0;
         m1_rd_data_od  <= '0;
         ovf_oh         <= 1'b0;
      end else begin
         s_rd_en_oh     <= 1'b0;
         s_wr_en_oh     <= 1'b0;
         m0_rd_valid_oh <= 1'b0;
         m0_wr_valid_oh <= 1'b0;
         m1_rd_valid_oh <= 1'b0;
         m1_wr_valid_oh <= 1'b0;
         if (ovf0 || ovf1) begin
            ovf_oh <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (any) begin
                  state        <= ISSUE;
                  gnt          <= pick;
                  cur_wr       <= sel.is_wr;
                  s_rd_en_oh   <= ~sel.is_wr;
                  s_wr_en_oh   <= sel.is_wr;
                  s_addr_od    <= P_ADDR_W'(sel.addr);
                  s_wr_data_od <= P_DATA_W'(sel.data);
               end
            end
            ISSUE, WAIT: begin
               if (done) begin
                  state <= RESP;
                  // Completion type follows the request, not the slave.
                  if (gnt) begin
                     m1_rd_valid_oh <= ~cur_wr;
                     m1_wr_valid_oh <= cur_wr;
                     if (!cur_wr) begin
                        m1_rd_data_od <= rsp;
                     end
                  end else begin
                     m0_rd_valid_oh <= ~cur_wr;
                     m0_wr_valid_oh <= cur_wr;
                     if (!cur_wr) begin
                        m0_rd_data_od <= rsp;
                     end
                  end
               end else begin
                  state <= WAIT;
               end
            end
            RESP: begin
               last  <= gnt;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_syn_cortex_lb_arb.sv
// tb_syn_cortex_lb_arb: scoreboard bench for syn_cortex_lb_arb.
// Slave model pops expected requests; monitor pops expected completions.
module tb_syn_cortex_lb_arb;

`ifdef SYN_CORTEX_LB_ARB_TIMEOUT_EN
   localparam int TOUT = 8;
`else
   localparam int TOUT = 255;
`endif

   typedef struct {
      bit          m;
      bit          wr;
      logic [15:0] addr;
      logic [31:0] data;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst_il = 1'b0;
   logic        m0_rd_en = 0, m0_wr_en = 0;
   logic [15:0] m0_addr = '0;
   logic [31:0] m0_wr_data = '0;
   logic        m0_rd_valid, m0_wr_valid;
   logic [31:0] m0_rd_data;
   logic        m1_rd_en = 0, m1_wr_en = 0;
   logic [15:0] m1_addr = '0;
   logic [31:0] m1_wr_data = '0;
   logic        m1_rd_valid, m1_wr_valid;
   logic [31:0] m1_rd_data;
   logic        s_rd_en, s_wr_en;
   logic [15:0] s_addr;
   logic [31:0] s_wr_data;
   logic        s_rd_valid = 0, s_wr_valid = 0;
   logic [31:0] s_rd_data = '0;
   logic        busy, ovf, tout;

   int   checks = 0;
   int   errors = 0;
   txn_t exp_s[$];
   txn_t exp_m[$];
   int   rsp_dly = 2;
   bit   rsp_en = 1'b1;
   bit   kick = 1'b0;
   int   s_issue_cnt = 0;
   int   rdv_cnt[2] = '{0, 0};
   int   wrv_cnt[2] = '{0, 0};

   always #5 clk = ~clk;

   syn_cortex_lb_arb #(
      .P_DATA_W  (32),
      .P_ADDR_W  (16),
      .P_TIMEOUT (TOUT)
   ) dut (
      .clk_ir         (clk),
      .rst_il         (rst_il),
      .m0_rd_en_ih    (m0_rd_en),
      .m0_wr_en_ih    (m0_wr_en),
      .m0_addr_id     (m0_addr),
      .m0_wr_data_id  (m0_wr_data),
      .m0_rd_valid_oh (m0_rd_valid),
      .m0_wr_valid_oh (m0_wr_valid),
      .m0_rd_data_od  (m0_rd_data),
      .m1_rd_en_ih    (m1_rd_en),
      .m1_wr_en_ih    (m1_wr_en),
      .m1_addr_id     (m1_addr),
      .m1_wr_data_id  (m1_wr_data),
      .m1_rd_valid_oh (m1_rd_valid),
      .m1_wr_valid_oh (m1_wr_valid),
      .m1_rd_data_od  (m1_rd_data),
      .s_rd_en_oh     (s_rd_en),
      .s_wr_en_oh     (s_wr_en),
      .s_addr_od      (s_addr),
      .s_wr_data_od   (s_wr_data),
      .s_rd_valid_ih  (s_rd_valid),
      .s_wr_valid_ih  (s_wr_valid),
      .s_rd_data_id   (s_rd_data),
      .busy_oh        (busy),
      .ovf_oh         (ovf),
      .tout_oh        (tout)
   );

   // Slave model: checks each request against exp_s, answers after rsp_dly.
   txn_t st;
   initial begin
      forever begin
         @(negedge clk);
         s_rd_valid = 1'b0;
         s_wr_valid = 1'b0;
         if (kick) begin
            s_rd_valid = 1'b1;
            kick = 1'b0;
         end
         if (rst_il && (s_rd_en || s_wr_en)) begin
            s_issue_cnt++;
            checks++;
            if (exp_s.size() == 0) begin
               errors++;
               $display("FAIL slave_req: got rd=%0b wr=%0b addr=%h, required none",
                        s_rd_en, s_wr_en, s_addr);
            end else begin
               st = exp_s.pop_front();
               if (s_wr_en !== st.wr || s_rd_en !== !st.wr ||
                   s_addr !== st.addr ||
                   (st.wr && s_wr_data !== st.data)) begin
                  errors++;
                  $display("FAIL slave_req: got wr=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                           s_wr_en, s_addr, s_wr_data, st.wr, st.addr, st.data);
               end
               if (rsp_en) begin
                  repeat (rsp_dly) @(negedge clk);
                  s_rd_valid = !st.wr;
                  s_wr_valid = st.wr;
                  s_rd_data  = st.wr ? 32'h0 : st.data;
               end
            end
         end
      end
   end

   // Completion monitor: checks every master valid against exp_m.
   txn_t mt;
   logic mrv, mwv;
   logic [31:0] mrd;
   initial begin
      forever begin
         @(negedge clk);
         for (int m = 0; m < 2; m++) begin
            mrv = (m == 1) ? m1_rd_valid : m0_rd_valid;
            mwv = (m == 1) ? m1_wr_valid : m0_wr_valid;
            mrd = (m == 1) ? m1_rd_data : m0_rd_data;
            if (rst_il && (mrv || mwv)) begin
               checks++;
               if (mrv) rdv_cnt[m]++;
               if (mwv) wrv_cnt[m]++;
               if (exp_m.size() == 0) begin
                  errors++;
                  $display("FAIL m%0d_valid: got rd=%0b wr=%0b, required no completion",
                           m, mrv, mwv);
               end else begin
                  mt = exp_m.pop_front();
                  if (int'(mt.m) != m || mwv !== mt.wr || mrv === mwv ||
                      (mrv && mrd !== mt.data)) begin
                     errors++;
                     $display("FAIL m%0d_valid: got rd=%0b wr=%0b data=%h, required m%0d wr=%0b data=%h",
                              m, mrv, mwv, mrd, mt.m, mt.wr, mt.data);
                  end
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1);
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic fire();
      step();
      m0_rd_en = 0; m0_wr_en = 0;
      m1_rd_en = 0; m1_wr_en = 0;
   endtask

   task automatic req(input bit m, input bit rd, input bit wr,
                      input logic [15:0] a, input logic [31:0] d);
      if (m) begin
         m1_rd_en = rd; m1_wr_en = wr; m1_addr = a; m1_wr_data = d;
      end else begin
         m0_rd_en = rd; m0_wr_en = wr; m0_addr = a; m0_wr_data = d;
      end
   endtask

   task automatic do_reset();
      rst_il = 1'b0;
      step();
      step();
      rst_il = 1'b1;
      step();
   endtask

   task automatic settle(input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         step();
         if (!busy && exp_s.size() == 0 && exp_m.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      step();
   endtask

   task automatic test_reset();
      rst_il = 1'b0;
      step();
      checks++;
      if ({busy, ovf, tout, s_rd_en, s_wr_en} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctl: got %b, required 00000",
                  {busy, ovf, tout, s_rd_en, s_wr_en});
      end
      checks++;
      if ({m0_rd_valid, m0_wr_valid, m1_rd_valid, m1_wr_valid} !== 4'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b, required 0000",
                  {m0_rd_valid, m0_wr_valid, m1_rd_valid, m1_wr_valid});
      end
      checks++;
      if ({s_addr, s_wr_data, m0_rd_data, m1_rd_data} !== 112'b0) begin
         errors++;
         $display("FAIL reset_data: got %h %h %h %h, required zeros",
                  s_addr, s_wr_data, m0_rd_data, m1_rd_data);
      end
      rst_il = 1'b1;
      step();
   endtask

   task automatic test_read();
      bit ok;
      rsp_dly = 3;
      exp_s.push_back('{0, 0, 16'h1004, 32'hA5A5_0001});
      exp_m.push_back('{0, 0, 16'h1004, 32'hA5A5_0001});
      req(0, 1, 0, 16'h1004, 32'h0);
      fire();
      checks++;
      if (s_rd_en !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL read_n1: got s_rd_en=%0b busy=%0b, required 0 0",
                  s_rd_en, busy);
      end
      step();
      checks++;
      if (s_rd_en !== 1'b1 || s_addr !== 16'h1004) begin
         errors++;
         $display("FAIL read_n2: got s_rd_en=%0b addr=%h, required 1 1004",
                  s_rd_en, s_addr);
      end
      repeat (3) step();
      checks++;
      if (m0_rd_valid !== 1'b0 || s_rd_valid !== 1'b1) begin
         errors++;
         $display("FAIL read_m: got m0_rd_valid=%0b s_rd_valid=%0b, required 0 1",
                  m0_rd_valid, s_rd_valid);
      end
      step();
      checks++;
      if (m0_rd_valid !== 1'b1 || m0_rd_data !== 32'hA5A5_0001 ||
          {m1_rd_valid, m1_wr_valid} !== 2'b0) begin
         errors++;
         $display("FAIL read_m1: got v=%0b data=%h m1=%b, required 1 a5a50001 00",
                  m0_rd_valid, m0_rd_data, {m1_rd_valid, m1_wr_valid});
      end
      settle(40, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL read_settle: bus still busy, required idle");
      end
   endtask

   task automatic test_round_robin();
      bit ok;
      int w0, w1;
      do_reset();
      rsp_dly = 1;
      w0 = wrv_cnt[0];
      w1 = wrv_cnt[1];
      for (int r = 0; r < 2; r++) begin
         // Fresh pair after both served: tie goes m0 first each round.
         exp_s.push_back('{0, 1, 16'h2000, 32'h11 + r});
         exp_s.push_back('{1, 1, 16'h1008, 32'h22 + r});
         exp_m.push_back('{0, 1, 16'h2000, 32'h0});
         exp_m.push_back('{1, 1, 16'h1008, 32'h0});
         req(0, 0, 1, 16'h2000, 32'h11 + r);
         req(1, 0, 1, 16'h1008, 32'h22 + r);
         fire();
         settle(60, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL rr_settle%0d: bus still busy, required idle", r);
         end
      end
      checks++;
      if (wrv_cnt[0] - w0 != 2 || wrv_cnt[1] - w1 != 2) begin
         errors++;
         $display("FAIL rr_count: got m0=%0d m1=%0d, required 2 2",
                  wrv_cnt[0] - w0, wrv_cnt[1] - w1);
      end
   endtask

   task automatic test_ovf();
      bit ok;
      int n;
      rsp_dly = 6;
      n = s_issue_cnt;
      exp_s.push_back('{1, 0, 16'h3000, 32'h77});
      exp_m.push_back('{1, 0, 16'h3000, 32'h77});
      req(1, 1, 0, 16'h3000, 32'h0);
      fire();
      step();
      step();
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_pre: got %0b, required 0", ovf);
      end
      req(1, 1, 0, 16'h3004, 32'h0);
      fire();
      checks++;
      if (ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set: got %0b, required 1", ovf);
      end
      settle(60, ok);
      repeat (5) step();
      checks++;
      if (!ok || s_issue_cnt - n != 1) begin
         errors++;
         $display("FAIL ovf_issue: got %0d slave reqs ok=%0b, required 1 1",
                  s_issue_cnt - n, ok);
      end
      checks++;
      if (ovf !== 1'b1 || m1_rd_data !== 32'h77) begin
         errors++;
         $display("FAIL ovf_hold: got ovf=%0b data=%h, required 1 00000077",
                  ovf, m1_rd_data);
      end
   endtask

   task automatic test_rdwr();
      bit ok;
      int r0, w0;
      logic [31:0] d0;
      rsp_dly = 2;
      r0 = rdv_cnt[0];
      w0 = wrv_cnt[0];
      d0 = m0_rd_data;
      exp_s.push_back('{0, 1, 16'h100C, 32'h5});
      exp_m.push_back('{0, 1, 16'h100C, 32'h0});
      req(0, 1, 1, 16'h100C, 32'h5);
      fire();
      settle(40, ok);
      checks++;
      if (!ok || wrv_cnt[0] - w0 != 1 || rdv_cnt[0] != r0) begin
         errors++;
         $display("FAIL rdwr_count: got wr=%0d rd=%0d ok=%0b, required 1 0 1",
                  wrv_cnt[0] - w0, rdv_cnt[0] - r0, ok);
      end
      checks++;
      if (m0_rd_data !== d0) begin
         errors++;
         $display("FAIL rdwr_data: got %h, required %h", m0_rd_data, d0);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int k;
      int w0;
      do_reset();
      rsp_dly = 0;
      w0 = wrv_cnt[0];
      exp_s.push_back('{0, 0, 16'h1010, 32'hC0DE});
      exp_m.push_back('{0, 0, 16'h1010, 32'hC0DE});
      exp_s.push_back('{0, 1, 16'h1020, 32'h99});
      exp_m.push_back('{0, 1, 16'h1020, 32'h0});
      req(0, 1, 0, 16'h1010, 32'h0);
      k = 0;
      for (int i = 1; i <= 10; i++) begin
         fire();
         if (m0_rd_valid === 1'b1) begin
            k = i;
            break;
         end
      end
      checks++;
      if (k != 3) begin
         errors++;
         $display("FAIL b2b_latency: got %0d cycles, required 3", k);
      end
      // New request in the owner's own RESP cycle.
      req(0, 0, 1, 16'h1020, 32'h99);
      fire();
      settle(40, ok);
      checks++;
      if (!ok || ovf !== 1'b0 || wrv_cnt[0] - w0 != 1) begin
         errors++;
         $display("FAIL b2b_resp_req: got ok=%0b ovf=%0b wr=%0d, required 1 0 1",
                  ok, ovf, wrv_cnt[0] - w0);
      end
   endtask

   task automatic test_hang();
      int k;
      rsp_en = 1'b0;
      exp_s.push_back('{0, 0, 16'h1040, 32'h0});
`ifdef SYN_CORTEX_LB_ARB_TIMEOUT_EN
      exp_m.push_back('{0, 0, 16'h1040, 32'hDEAD_BEEF});
`endif
      req(0, 1, 0, 16'h1040, 32'h0);
      for (int i = 0; i < 5; i++) begin
         fire();
         if (s_rd_en === 1'b1) break;
      end
`ifdef SYN_CORTEX_LB_ARB_TIMEOUT_EN
      k = 0;
      for (int i = 1; i <= 30; i++) begin
         step();
         if (m0_rd_valid === 1'b1) begin
            k = i;
            break;
         end
      end
      checks++;
      if (k < 9 || k > 10 || m0_rd_data !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL tout_resp: got %0d cycles data=%h, required 9..10 deadbeef",
                  k, m0_rd_data);
      end
      checks++;
      if (tout !== 1'b1) begin
         errors++;
         $display("FAIL tout_flag: got %0b, required 1", tout);
      end
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL tout_busy: got %0b, required 0", busy);
      end
`else
      k = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (busy === 1'b1) k++;
      end
      checks++;
      if (k != 40 || tout !== 1'b0) begin
         errors++;
         $display("FAIL hang_busy: got busy %0d/40 tout=%0b, required 40 0",
                  k, tout);
      end
`endif
   endtask

   task automatic test_reset_wait();
      int n, r0, r1;
`ifdef SYN_CORTEX_LB_ARB_TIMEOUT_EN
      exp_s.push_back('{0, 0, 16'h1050, 32'h0});
      req(0, 1, 0, 16'h1050, 32'h0);
      fire();
      step();
      step();
`endif
      req(1, 1, 0, 16'h2050, 32'h0);
      fire();
      n = s_issue_cnt;
      r0 = rdv_cnt[0];
      r1 = rdv_cnt[1];
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL rstw_pre: got busy=%0b, required 1", busy);
      end
      rst_il = 1'b0;
      #1;
      checks++;
      if ({busy, ovf, tout, s_rd_en, s_wr_en, m0_rd_valid, m1_rd_valid,
           s_addr, m0_rd_data} !== '0) begin
         errors++;
         $display("FAIL rstw_out: got busy=%0b ovf=%0b tout=%0b addr=%h, required zeros",
                  busy, ovf, tout, s_addr);
      end
      step();
      rst_il = 1'b1;
      kick = 1'b1;
      repeat (6) step();
      checks++;
      if (s_issue_cnt != n || busy !== 1'b0) begin
         errors++;
         $display("FAIL rstw_pend: got %0d slave reqs busy=%0b, required 0 0",
                  s_issue_cnt - n, busy);
      end
      checks++;
      if (rdv_cnt[0] != r0 || rdv_cnt[1] != r1) begin
         errors++;
         $display("FAIL rstw_late: got m0=%0d m1=%0d valids, required 0 0",
                  rdv_cnt[0] - r0, rdv_cnt[1] - r1);
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_round_robin();
      test_ovf();
      test_rdwr();
      test_back_to_back();
      test_hang();
      test_reset_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
